// File: rtl/vga_timing_pkg.sv
// Shared 640x480 @ 60 Hz timing constants, coordinate type and sync decode
// helpers for the VGA timing generator.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } sync_t;

    localparam int PIX_DIV_DEF = 4;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;

    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL      = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int H_SYNC_START = H_DISPLAY_DEF + H_FRONT_DEF;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;

    localparam int V_TOTAL      = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
    localparam int V_SYNC_START = V_DISPLAY_DEF + V_FRONT_DEF;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

    // Wrap is an explicit compare against the last legal value, never an overflow.
    function automatic coord_t wrap_inc(input coord_t value, input coord_t last);
        return (value == last) ? '0 : value + coord_t'(1);
    endfunction

    // Sync pulses are active low; the bounds are inclusive.
    function automatic sync_t decode_sync(
        input coord_t x,
        input coord_t y,
        input coord_t h_display,
        input coord_t hs_start,
        input coord_t hs_end,
        input coord_t v_display,
        input coord_t vs_start,
        input coord_t vs_end
    );
        sync_t s;
        s.hsync    = !((x >= hs_start) && (x <= hs_end));
        s.vsync    = !((y >= vs_start) && (y <= vs_end));
        s.video_on = (x < h_display) && (y < v_display);
        return s;
    endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate prescaler: emits a registered one-cycle strobe every PIX_DIV
// clock cycles, first strobe PIX_DIV cycles after reset release.
module vga_pix_div
    import vga_timing_pkg::*;
#(
    parameter int PIX_DIV = PIX_DIV_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_p_tick
);

    localparam int                DIV_W    = $clog2(PIX_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_p_tick;

    // The strobe is registered from the terminal count, so it is high in the
    // cycle following the one in which the counter sits at its last value.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values and simulation matches hardware.
        if (i_rst) begin
            r_div_cnt <= '0;
            r_p_tick  <= 1'b0;
        end else begin
            r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DIV_W'(1);
            r_p_tick  <= (r_div_cnt == DIV_LAST);
        end
    end

    assign o_p_tick = r_p_tick;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA 640x480 @ 60 Hz timing generator: pixel prescaler, H/V position counters
// and zero-skew registered sync decode. Optional frame strobe: VGA_SYNC_FRAME_TICK_EN.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int PIX_DIV   = PIX_DIV_DEF,
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic               clkvga,
    input  logic               rst,
`ifdef VGA_SYNC_FRAME_TICK_EN
    output logic               frame_tick,
`endif
    output logic               p_tick,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on
);

    localparam coord_t H_LAST     = coord_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam coord_t H_DISP_C   = coord_t'(H_DISPLAY);
    localparam coord_t HS_START_C = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_END_C   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);

    localparam coord_t V_LAST     = coord_t'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam coord_t V_DISP_C   = coord_t'(V_DISPLAY);
    localparam coord_t VS_START_C = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_END_C   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    localparam sync_t SYNC_RESET = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0};

    logic   w_p_tick;
    logic   w_end_of_line;
    coord_t w_x_next;
    coord_t w_y_next;
    sync_t  w_sync_next;

    coord_t r_x;
    coord_t r_y;
    sync_t  r_sync;

    vga_pix_div #(
        .PIX_DIV (PIX_DIV)
    ) u_pix_div (
        .i_clk    (clkvga),
        .i_rst    (rst),
        .o_p_tick (w_p_tick)
    );

    assign w_end_of_line = (r_x == H_LAST);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_p_tick) begin
            w_x_next = wrap_inc(r_x, H_LAST);
            if (w_end_of_line) begin
                w_y_next = wrap_inc(r_y, V_LAST);
            end
        end
    end

    // Decoding the next position keeps the sync outputs aligned with x/y.
    assign w_sync_next = decode_sync(w_x_next, w_y_next,
                                     H_DISP_C, HS_START_C, HS_END_C,
                                     V_DISP_C, VS_START_C, VS_END_C);

    always_ff @(posedge clkvga) begin
        if (rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_sync <= SYNC_RESET;
        end else begin
            r_x    <= w_x_next;
            r_y    <= w_y_next;
            r_sync <= w_sync_next;
        end
    end

`ifdef VGA_SYNC_FRAME_TICK_EN
    logic r_frame_tick;

    // Fires on the edge that returns the position to (0,0) from the last pixel,
    // which reset release never does.
    always_ff @(posedge clkvga) begin
        if (rst) begin
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_p_tick && w_end_of_line && (r_y == V_LAST);
        end
    end

    assign frame_tick = r_frame_tick;
`endif

    assign p_tick   = w_p_tick;
    assign x        = r_x;
    assign y        = r_y;
    assign hsync    = r_sync.hsync;
    assign vsync    = r_sync.vsync;
    assign video_on = r_sync.video_on;

endmodule
